// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and writeback arbiter state type.
package rf_pkg;
   localparam int RF_ADDR_W = 5;
   localparam int NUM_REGS  = 32;
   typedef enum logic {WBA_NORMAL, WBA_FORCE1} wba_state_t;
endpackage

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the regfile write port between the pipeline WB stage (priority)
// and a multi-cycle unit, with an age counter that forces a port-1 grant.
import rf_pkg::*;
module rf_wb_arbiter #(
   parameter int REG_WIDTH = 32,
   parameter int MAX_WAIT  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wb0_valid,
   output logic                 wb0_ready,
   input  logic [RF_ADDR_W-1:0] wb0_rd,
   input  logic [REG_WIDTH-1:0] wb0_data,
   input  logic                 wb1_valid,
   output logic                 wb1_ready,
   input  logic [RF_ADDR_W-1:0] wb1_rd,
   input  logic [REG_WIDTH-1:0] wb1_data,
   output logic                 rf_reg_write,
   output logic [RF_ADDR_W-1:0] rf_rd,
   output logic [REG_WIDTH-1:0] rf_rd_din
);
   localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT - 1);
   wba_state_t state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic rf_we_q, rf_we_d;
   logic [RF_ADDR_W-1:0] rf_rd_q, rf_rd_d;
   logic [REG_WIDTH-1:0] rf_din_q, rf_din_d;
   logic xfer0, xfer1, blocked1;
   always_comb begin
      wb0_ready = !reset && state_q == WBA_NORMAL;
      wb1_ready = !reset && (state_q == WBA_FORCE1 || !wb0_valid);
      xfer0 = wb0_valid && wb0_ready;
      xfer1 = wb1_valid && wb1_ready;
      blocked1 = wb1_valid && !wb1_ready;
      wait_d = (xfer1 || state_q == WBA_FORCE1) ? 8'd0 : blocked1 ? wait_q + 8'd1 : wait_q;
      state_d = (state_q == WBA_NORMAL && blocked1 && wait_q == WAIT_LIM) ? WBA_FORCE1 : WBA_NORMAL;
      rf_we_d = xfer0 ? (wb0_rd != '0) : xfer1 ? (wb1_rd != '0) : 1'b0;
      rf_rd_d = xfer0 ? wb0_rd : xfer1 ? wb1_rd : rf_rd_q;
      rf_din_d = xfer0 ? wb0_data : xfer1 ? wb1_data : rf_din_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= WBA_NORMAL;
         wait_q   <= '0;
         rf_we_q  <= 1'b0;
         rf_rd_q  <= '0;
         rf_din_q <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         rf_we_q  <= rf_we_d;
         rf_rd_q  <= rf_rd_d;
         rf_din_q <= rf_din_d;
      end
   end
   assign rf_reg_write = rf_we_q;
   assign rf_rd        = rf_rd_q;
   assign rf_rd_din    = rf_din_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and random writeback traffic against a request-age reference model.
module tb_rf_wb_arbiter;
   localparam int MW = 4;
   logic clk = 1'b0, reset = 1'b1;
   logic v0 = 1'b0, v1 = 1'b0;
   logic [4:0] rd0 = '0, rd1 = '0;
   logic [31:0] d0 = '0, d1 = '0;
   logic wb0_ready, wb1_ready, rf_reg_write;
   logic [4:0] rf_rd;
   logic [31:0] rf_rd_din;
   int n_tests = 0, n_fail = 0;
   int blocked = 0;
   logic m_we = 1'b0;
   logic [4:0] m_rd = '0;
   logic [31:0] m_din = '0;
   logic [31:0] m_mem [32];
   logic [31:0] dut_mem [32];
   bit g0, g1;
   always #5 clk = ~clk;
   rf_wb_arbiter #(.REG_WIDTH(32), .MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset),
      .wb0_valid(v0), .wb0_ready(wb0_ready), .wb0_rd(rd0), .wb0_data(d0),
      .wb1_valid(v1), .wb1_ready(wb1_ready), .wb1_rd(rd1), .wb1_data(d1),
      .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_rd_din(rf_rd_din)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   // One clock: the port-1 request is forced once it has been refused MW cycles.
   task automatic cycle(output bit t0, output bit t1);
      bit forced, e0, e1;
      #3;
      forced = !reset && v1 && blocked >= MW;
      e0 = !reset && !forced;
      e1 = !reset && (forced || !v0);
      check("wb0_ready", wb0_ready, e0);
      check("wb1_ready", wb1_ready, e1);
      check("rf_reg_write", rf_reg_write, m_we);
      check("rf_rd", rf_rd, m_rd);
      check("rf_rd_din", rf_rd_din, m_din);
      if (rf_reg_write === 1'b1 && rf_rd != 0) dut_mem[rf_rd] = rf_rd_din;
      t0 = v0 && e0;
      t1 = v1 && e1 && !t0;
      @(posedge clk);
      if (reset) begin
         m_we = 0; m_rd = 0; m_din = 0; blocked = 0;
      end else begin
         if (t0) begin m_we = rd0 != 0; m_rd = rd0; m_din = d0; end
         else if (t1) begin m_we = rd1 != 0; m_rd = rd1; m_din = d1; end
         else m_we = 0;
         if (m_we) m_mem[m_rd] = m_din;
         blocked = t1 ? 0 : (v1 && !e1) ? blocked + 1 : blocked;
      end
      #1;
   endtask
   task automatic new0();
      v0 = 1; rd0 = 5'($urandom_range(1, 31)); d0 = $urandom;
   endtask
   initial begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = 0; dut_mem[i] = 0; end
      @(posedge clk); #1;
      v0 = 1; v1 = 1; rd0 = 9; rd1 = 10; d0 = 32'h11; d1 = 32'h22;
      repeat (3) cycle(g0, g1);
      reset = 0; v0 = 0; v1 = 0;
      cycle(g0, g1);
      v0 = 1; rd0 = 5; d0 = 32'hDEADBEEF;
      cycle(g0, g1);
      v0 = 0;
      repeat (2) cycle(g0, g1);
      new0(); v1 = 1; rd1 = 7; d1 = 32'h1234;
      for (int k = 0; k < 8; k++) begin
         cycle(g0, g1);
         if (g0) new0();
         if (g1) v1 = 0;
      end
      v0 = 0; v1 = 1; rd1 = 0; d1 = 32'hFFFFFFFF;
      cycle(g0, g1);
      if (g1) v1 = 0;
      repeat (2) cycle(g0, g1);
      new0(); v1 = 1; rd1 = 12; d1 = 32'hBAD;
      for (int k = 0; k < 12 && blocked < MW; k++) begin
         cycle(g0, g1);
         if (g0) new0();
      end
      reset = 1;
      cycle(g0, g1);
      reset = 0; v1 = 0;
      repeat (2) begin cycle(g0, g1); if (g0) new0(); end
      v1 = 1; rd1 = 13; d1 = 32'h5A5A;
      for (int k = 0; k < 8; k++) begin
         cycle(g0, g1);
         if (g0) new0();
         if (g1) v1 = 0;
      end
      v1 = 1; rd1 = 3; d1 = 32'h77;
      for (int k = 0; k < 12 && v1; k++) begin
         if (blocked == MW - 1 && v0) begin
            cycle(g0, g1);
            if (g0) begin v0 = 1; rd0 = 3; d0 = 32'hA; end
         end else begin
            cycle(g0, g1);
            if (g0) new0();
         end
         if (g1) v1 = 0;
      end
      for (int k = 0; k < 4 && v0; k++) begin
         cycle(g0, g1);
         if (g0) v0 = 0;
      end
      cycle(g0, g1);
      check("same_rd_x3", dut_mem[3], 32'hA);
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         if (!v0 && $urandom_range(0, 3) != 0) begin
            v0 = 1; rd0 = 5'($urandom); d0 = $urandom;
         end
         if (!v1 && $urandom_range(0, 2) == 0) begin
            v1 = 1; rd1 = 5'($urandom); d1 = $urandom;
         end
         cycle(g0, g1);
         if (g0) v0 = 0;
         if (g1) v1 = 0;
      end
      reset = 0; v0 = 0; v1 = 0;
      repeat (2) cycle(g0, g1);
      for (int i = 0; i < 32; i++) check($sformatf("regfile_x%0d", i), dut_mem[i], m_mem[i]);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
